alu_sequencer: RTL and testbench

Multi-cycle controller that owns the 16-bit accumulator in front of the team's combinational ALU (opcodes 0–6) and sequences it. It accepts one command per valid/ready handshake and either loads the accumulator directly or drives the ALU repeatedly (1 to 2^CNT_W iterations), writing W back into the accumulator each cycle. When the command finishes it latches the zero/negative flags and pulses done. It sits between a host or test driver and the ALU instance, which is instantiated outside this block.

---
 rtl/alu_sequencer_if.sv | 24 ++
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command handshake bundle between a host/driver and alu_sequencer.
// The master drives the command fields; the slave returns cmd_ready.
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [2:0]       cmd_opc;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_cin;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (
    output cmd_valid, cmd_load, cmd_opc, cmd_b, cmd_cin, cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_opc, cmd_b, cmd_cin, cmd_cnt,
    output cmd_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator owner and multi-cycle sequencer for the external combinational ALU.
// Accepts one command per handshake: a direct load, or 1..2^CNT_W ALU iterations.
module alu_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_c,
  output logic [2:0]       alu_opc,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_zer,
  input  logic             alu_neg,
  output logic [WIDTH-1:0] acc,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OPC_PARK = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic [2:0]       opc_q, opc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_c_q, alu_c_d;
  logic [2:0]       alu_opc_q, alu_opc_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    opc_d   = opc_q;
    b_d     = b_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          if (cmd.cmd_load) begin
            acc_d   = cmd.cmd_b;
            zero_d  = (cmd.cmd_b == '0);
            neg_d   = cmd.cmd_b[WIDTH-1];
            state_d = DONE;
          end else begin
            opc_d   = cmd.cmd_opc;
            b_d     = cmd.cmd_b;
            cin_d   = cmd.cmd_cin;
            cnt_d   = cmd.cmd_cnt;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        acc_d  = alu_w;
        zero_d = alu_zer;
        neg_d  = alu_neg;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the upcoming state so they line up with it after the edge.
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    alu_b_d   = (state_d == EXEC) ? b_d   : '0;
    alu_c_d   = (state_d == EXEC) ? cin_d : 1'b0;
    alu_opc_d = (state_d == EXEC) ? opc_d : OPC_PARK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      zero_q    <= 1'b1;
      neg_q     <= 1'b0;
      opc_q     <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_b_q   <= '0;
      alu_c_q   <= 1'b0;
      alu_opc_q <= OPC_PARK;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      opc_q     <= opc_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      alu_b_q   <= alu_b_d;
      alu_c_q   <= alu_c_d;
      alu_opc_q <= alu_opc_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign acc           = acc_q;
  assign zero_flag     = zero_q;
  assign neg_flag      = neg_q;
  assign alu_a         = acc_q;
  assign alu_b         = alu_b_q;
  assign alu_c         = alu_c_q;
  assign alu_opc       = alu_opc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural stand-in for the external ALU.
module tb_alu_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] alu_a, alu_b, alu_w, acc;
  logic             alu_c, alu_zer, alu_neg;
  logic [2:0]       alu_opc;
  logic             zero_flag, neg_flag, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  alu_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

  alu_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_opc   (alu_opc),
    .alu_w     (alu_w),
    .alu_zer   (alu_zer),
    .alu_neg   (alu_neg),
    .acc       (acc),
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag),
    .busy      (busy),
    .done      (done)
  );

  // ALU stand-in: 0 negate, 1 increment, 2 add with carry, 3 subtract,
  // 4 and, 5 or, 6 byte merge {A[7:0],B[7:0]}, 7 zero.
  always_comb begin
    case (alu_opc)
      3'd0:    alu_w = 16'(-alu_a);
      3'd1:    alu_w = 16'(alu_a + 16'd1);
      3'd2:    alu_w = 16'(alu_a + alu_b + {15'd0, alu_c});
      3'd3:    alu_w = 16'(alu_a - alu_b);
      3'd4:    alu_w = alu_a & alu_b;
      3'd5:    alu_w = alu_a | alu_b;
      3'd6:    alu_w = {alu_a[7:0], alu_b[7:0]};
      default: alu_w = 16'd0;
    endcase
    alu_zer = (alu_w == 16'd0);
    alu_neg = alu_w[15];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for exactly one edge; caller ensures the DUT is idle.
  task automatic issue(input logic load, input logic [2:0] opc, input logic [15:0] b,
                       input logic cin, input logic [3:0] cnt);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = load;
    cmd_if.cmd_opc   = opc;
    cmd_if.cmd_b     = b;
    cmd_if.cmd_cin   = cin;
    cmd_if.cmd_cnt   = cnt;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Latency counts edges from the acceptance edge (inclusive) until done is seen.
  task automatic wait_done(input int start, output int lat, output int bad);
    lat = start;
    bad = 0;
    while (done !== 1'b1 && lat < 64) begin
      if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) bad++;
      tick();
      lat++;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    int lat, bad;
    issue(1'b1, 3'd0, v, 1'b0, 4'd0);
    wait_done(1, lat, bad);
    tick();
  endtask

  initial begin
    int lat, bad;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_load  = 1'b0;
    cmd_if.cmd_opc   = 3'd0;
    cmd_if.cmd_b     = 16'd0;
    cmd_if.cmd_cin   = 1'b0;
    cmd_if.cmd_cnt   = 4'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_acc",   32'(acc), 32'h0);
    chk("rst_zero",  32'(zero_flag), 32'h1);
    chk("rst_neg",   32'(neg_flag), 32'h0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_opc",   32'(alu_opc), 32'h4);

    // Load 0x0005
    issue(1'b1, 3'd7, 16'h0005, 1'b1, 4'hF);
    wait_done(1, lat, bad);
    chk("ld_lat",  32'(lat), 32'd1);
    chk("ld_acc",  32'(acc), 32'h0005);
    chk("ld_zero", 32'(zero_flag), 32'h0);
    tick();
    chk("ld_pulse", 32'(done), 32'h0);
    chk("ld_ready", 32'(cmd_if.cmd_ready), 32'h1);

    // Increment x4
    issue(1'b0, 3'd1, 16'h0001, 1'b0, 4'd3);
    chk("inc_opc", 32'(alu_opc), 32'h1);
    wait_done(1, lat, bad);
    chk("inc_lat",  32'(lat), 32'd5);
    chk("inc_busy", 32'(bad), 32'd0);
    chk("inc_acc",  32'(acc), 32'h0009);
    chk("inc_bdone", 32'(busy), 32'h1);
    tick();

    // Add with carry wrapping to zero
    do_load(16'hFFFC);
    chk("add_neg0", 32'(neg_flag), 32'h1);
    issue(1'b0, 3'd2, 16'h0003, 1'b1, 4'd0);
    chk("add_a",   32'(alu_a), 32'hFFFC);
    chk("add_b",   32'(alu_b), 32'h0003);
    chk("add_c",   32'(alu_c), 32'h1);
    chk("add_opc", 32'(alu_opc), 32'h2);
    wait_done(1, lat, bad);
    chk("add_lat",  32'(lat), 32'd2);
    chk("add_acc",  32'(acc), 32'h0000);
    chk("add_zero", 32'(zero_flag), 32'h1);
    chk("add_neg",  32'(neg_flag), 32'h0);
    tick();
    chk("park_opc", 32'(alu_opc), 32'h4);
    chk("park_b",   32'(alu_b), 32'h0);
    chk("park_c",   32'(alu_c), 32'h0);

    // Byte merge twice
    do_load(16'h1234);
    issue(1'b0, 3'd6, 16'h00AB, 1'b0, 4'd1);
    tick();
    chk("mrg_it1", 32'(acc), 32'h34AB);
    wait_done(2, lat, bad);
    chk("mrg_lat", 32'(lat), 32'd3);
    chk("mrg_acc", 32'(acc), 32'hABAB);
    chk("mrg_neg", 32'(neg_flag), 32'h1);
    chk("mrg_zero", 32'(zero_flag), 32'h0);
    tick();

    // Sixteen negations with a competing load held on the bus
    do_load(16'h0042);
    issue(1'b0, 3'd0, 16'h0000, 1'b0, 4'hF);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = 1'b1;
    cmd_if.cmd_b     = 16'h7777;
    wait_done(1, lat, bad);
    chk("neg_lat",  32'(lat), 32'd17);
    chk("neg_busy", 32'(bad), 32'd0);
    chk("neg_acc",  32'(acc), 32'h0042);
    tick();
    chk("neg_idle_ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("neg_idle_acc",   32'(acc), 32'h0042);
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("pend_done", 32'(done), 32'h1);
    chk("pend_acc",  32'(acc), 32'h7777);
    tick();

    // Opcode 7 clears the accumulator
    issue(1'b0, 3'd7, 16'hFFFF, 1'b1, 4'd0);
    wait_done(1, lat, bad);
    chk("z7_acc",  32'(acc), 32'h0);
    chk("z7_zero", 32'(zero_flag), 32'h1);
    tick();

    // Reset during the third EXEC cycle
    do_load(16'h0100);
    issue(1'b0, 3'd1, 16'h0001, 1'b0, 4'd7);
    tick();
    tick();
    chk("ab_pre", 32'(acc), 32'h0102);
    rst = 1'b1;
    #1;
    chk("ab_acc",   32'(acc), 32'h0);
    chk("ab_ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("ab_busy",  32'(busy), 32'h0);
    chk("ab_zero",  32'(zero_flag), 32'h1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 1'b0) bad++;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b0) bad++;
    end
    chk("ab_nodone", 32'(bad), 32'd0);
    chk("ab_idle",   32'(acc), 32'h0);
    issue(1'b1, 3'd0, 16'h80A5, 1'b0, 4'd0);
    wait_done(1, lat, bad);
    chk("ab_ld_lat", 32'(lat), 32'd1);
    chk("ab_ld_acc", 32'(acc), 32'h80A5);
    chk("ab_ld_neg", 32'(neg_flag), 32'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
